// File: rtl/moore_ser_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : moore_ser_pkg                                                   |
// | Purpose  : Shared types and constants for the Moore pattern serializer:    |
// |            FSM state encoding, default geometry, bit-index width helper.   |
// | Ports    : none (package)                                                  |
// | Options  : SER_PARITY_EN (consumed by moore_pattern_serializer)            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package moore_ser_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } ser_state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DIV_W = 4;

    // Wide enough to hold WIDTH itself, which the parity build uses as the
    // starting bit index (WIDTH data bits plus one parity slot at index 0).
    function automatic int idx_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int BIT_IDX_W = $clog2(DEF_WIDTH + 1);

endpackage : moore_ser_pkg
`default_nettype wire

// File: rtl/moore_bit_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : moore_bit_timer                                                 |
// | Purpose  : DIV_W-bit down-counter pacing one serial bit. Loads a period,   |
// |            counts down to zero and holds there; tc_o flags count == 0.     |
// | Ports    : clk, rst_n (sync, active-low)                                   |
// |            load_i      - load load_val_i this clock (has priority)         |
// |            load_val_i  - period value, clocks per bit minus 1              |
// |            tc_o        - terminal count, timer is zero                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module moore_bit_timer #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [DIV_W-1:0] load_val_i,
    output logic             tc_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // Saturates at zero so the maximum period never wraps around.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule : moore_bit_timer
`default_nettype wire

// File: rtl/moore_pattern_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : moore_pattern_serializer                                        |
// | Purpose  : Accepts a WIDTH-bit pattern over valid/ready and shifts it out  |
// |            MSB-first, each bit held bit_period+1 clocks. Optional gapless  |
// |            repeat. Drives the serial Moore sequence detector input.        |
// | Ports    : clk, rst_n (sync, active-low)                                   |
// |            load_valid/load_ready/load_data - pattern word handshake        |
// |            bit_period - clocks per bit minus 1, captured at handshake      |
// |            repeat_en  - restart frame after last bit when high             |
// |            ser_out    - serial data          bit_strobe - new bit pulse    |
// |            busy       - frame in progress    done       - end pulse        |
// | Options  : SER_PARITY_EN - append one even-parity bit after the LSB        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module moore_pattern_serializer
    import moore_ser_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [DIV_W-1:0] bit_period,
    input  logic             repeat_en,
    output logic             ser_out,
    output logic             bit_strobe,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = idx_width(WIDTH);

    // Index counts down to 0 on the last slot of a frame. With parity the
    // frame has one more slot, so it starts one higher.
`ifdef SER_PARITY_EN
    localparam logic [IDX_W-1:0] IDX_START = IDX_W'(WIDTH);
`else
    localparam logic [IDX_W-1:0] IDX_START = IDX_W'(WIDTH - 1);
`endif

    ser_state_t       state_q,  state_d;
    logic [WIDTH-1:0] shreg_q,  shreg_d;
    logic [WIDTH-1:0] word_q,   word_d;
    logic [DIV_W-1:0] period_q, period_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic             strobe_q, strobe_d;

    logic             tmr_load;
    logic [DIV_W-1:0] tmr_val;
    logic             tmr_tc;

    moore_bit_timer #(
        .DIV_W (DIV_W)
    ) u_bit_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tc_o       (tmr_tc)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        word_d   = word_q;
        period_d = period_q;
        idx_d    = idx_q;
        strobe_d = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = period_q;

        case (state_q)
            S_IDLE: begin
                if (load_valid) begin
                    shreg_d  = load_data;
                    word_d   = load_data;
                    period_d = bit_period;
                    idx_d    = IDX_START;
                    tmr_load = 1'b1;
                    tmr_val  = bit_period;
                    strobe_d = 1'b1;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (tmr_tc) begin
                    if (idx_q != '0) begin
                        shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
                        idx_d    = idx_q - 1'b1;
                        tmr_load = 1'b1;
                        strobe_d = 1'b1;
                    end else if (repeat_en) begin
                        // Gapless restart: next MSB follows the last slot directly.
                        shreg_d  = word_q;
                        idx_d    = IDX_START;
                        tmr_load = 1'b1;
                        strobe_d = 1'b1;
                    end else begin
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            word_q   <= '0;
            period_q <= '0;
            idx_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            word_q   <= word_d;
            period_q <= period_d;
            idx_q    <= idx_d;
            strobe_q <= strobe_d;
        end
    end

    // Moore outputs: decoded from registered state only.
    assign load_ready = (state_q == S_IDLE);
    assign busy       = (state_q == S_SHIFT);
    assign done       = (state_q == S_DONE);
    assign bit_strobe = strobe_q;

`ifdef SER_PARITY_EN
    // Index 0 is the parity slot; data bits occupy indices WIDTH..1.
    assign ser_out = busy & ((idx_q == '0) ? (^word_q) : shreg_q[WIDTH-1]);
`else
    assign ser_out = busy & shreg_q[WIDTH-1];
`endif

endmodule : moore_pattern_serializer
`default_nettype wire

// File: tb/tb_moore_pattern_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_moore_pattern_serializer                                     |
// | Purpose  : Scoreboard bench for moore_pattern_serializer. Stimulus pushes  |
// |            expected bit/done events with their cycle; a monitor pops and   |
// |            compares on every bit_strobe or done. Includes a 1101 Moore     |
// |            detector model fed from ser_out (loopback).                     |
// | Options  : SER_PARITY_EN - expects the extra parity bit per frame          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_moore_pattern_serializer;

    localparam int W  = 8;
    localparam int DW = 4;
`ifdef SER_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    typedef struct {
        int   cyc;
        bit   is_done;
        logic val;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_valid;
    logic          load_ready;
    logic [W-1:0]  load_data;
    logic [DW-1:0] bit_period;
    logic          repeat_en;
    logic          ser_out;
    logic          bit_strobe;
    logic          busy;
    logic          done;

    int  cyc = 0;
    int  n_total = 0;
    int  n_pass = 0;
    int  det_count = 0;
    bit  mon_en = 1'b0;
    bit  prev_done = 1'b0;
    logic [3:0] hist = 4'b0;
    ev_t q[$];

    moore_pattern_serializer #(
        .WIDTH (W),
        .DIV_W (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .bit_period (bit_period),
        .repeat_en  (repeat_en),
        .ser_out    (ser_out),
        .bit_strobe (bit_strobe),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc + 1);
    endtask

    // Monitor: spec cycle of the interval being sampled is cyc+1.
    always @(negedge clk) begin
        ev_t e;
        if (mon_en) begin
            if (prev_done) check("ready_after_done", {31'd0, load_ready}, 32'd1);
            prev_done = (done === 1'b1);
            if (bit_strobe === 1'b1 || done === 1'b1) begin
                if (q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_event: got strobe=%0b done=%0b expected none (cycle %0d)",
                             bit_strobe, done, cyc + 1);
                end else begin
                    e = q.pop_front();
                    check("ev_cycle", cyc + 1, e.cyc);
                    check("ev_kind", {31'd0, done}, {31'd0, e.is_done});
                    if (e.is_done) begin
                        check("done_idle_outs", {29'd0, busy, ser_out, load_ready}, 32'd0);
                    end else begin
                        check("ev_bit", {31'd0, ser_out}, {31'd0, e.val});
                        check("ev_busy", {30'd0, busy, load_ready}, 32'd2);
                    end
                end
            end
        end
    end

    // Loopback 1101 Moore detector model, advanced once per serial bit.
    always @(negedge clk) begin
        if (mon_en && bit_strobe === 1'b1) begin
            hist = {hist[2:0], ser_out};
            if (hist == 4'b1101) det_count++;
        end
    end

    function automatic logic exp_bit(input logic [W-1:0] d, input int b);
        if (b < W) return d[W-1-b];
        return ^d;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (load_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {31'd0, load_ready}, 32'd1);
    endtask

    task automatic push_frames(input logic [W-1:0] d, input int p, input int k,
                               input int frames, input int limit, input bit with_done);
        int n = 0;
        for (int f = 0; f < frames; f++) begin
            for (int b = 0; b < NB; b++) begin
                if (n < limit) q.push_back('{k + 1 + (f * NB + b) * (p + 1), 1'b0, exp_bit(d, b)});
                n++;
            end
        end
        if (with_done) q.push_back('{k + frames * NB * (p + 1) + 1, 1'b1, 1'b0});
    endtask

    // Drives one handshake; expectations are queued before the capturing edge.
    task automatic start_frame(input logic [W-1:0] d, input int p, input int frames,
                               input int limit, input bit with_done, output int k);
        wait_ready();
        load_data  = d;
        bit_period = DW'(p);
        load_valid = 1'b1;
        k = cyc + 1;
        push_frames(d, p, k, frames, limit, with_done);
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("drain", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        int kb;
        int d0;
        rst_n = 1'b0; load_valid = 1'b0; load_data = '0; bit_period = '0; repeat_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ser_out", {31'd0, ser_out}, 32'd0);
        check("rst_strobe", {31'd0, bit_strobe}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ready", {31'd0, load_ready}, 32'd1);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // 1: D0 at one clock per bit, plus loopback detection
        d0 = det_count;
        start_frame(8'hD0, 0, 1, 999, 1'b1, k);
        drain();
        check("det_1101_frame", {31'd0, det_count > d0}, 32'd1);

        // 2: D0 with P=3, then max period on another pattern
        start_frame(8'hD0, 3, 1, 999, 1'b1, k);
        drain();
        start_frame(8'h81, 15, 1, 999, 1'b1, k);
        drain();
        start_frame(8'hA5, 0, 1, 999, 1'b1, k);
        drain();

        // 3: three gapless frames, repeat_en dropped inside the third
        repeat_en = 1'b1;
        start_frame(8'hD0, 1, 3, 999, 1'b1, k);
        while (cyc + 1 < k + 2 * NB * 2 + 4) @(negedge clk);
        repeat_en = 1'b0;
        drain();

        // 4: new word held during busy must wait for the next IDLE cycle
        start_frame(8'hD0, 0, 1, 999, 1'b1, k);
        kb = k + NB + 2;
        load_data  = 8'h2C;
        bit_period = 4'd1;
        load_valid = 1'b1;
        push_frames(8'h2C, 1, kb, 1, 999, 1'b1);
        while (cyc < kb) @(negedge clk);
        load_valid = 1'b0;
        drain();

        // 5: reset at bit 4 of a frame aborts without done
        d0 = det_count;
        start_frame(8'hD0, 0, 1, 4, 1'b0, k);
        while (cyc + 1 < k + 4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_outs", {27'd0, ser_out, busy, done, bit_strobe, load_ready}, 32'd1);
        check("det_1101_abort", {31'd0, det_count > d0}, 32'd1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_queue", q.size(), 0);

        // 6: parity build adds ^word as 9th bit; covered by the same frames above
        start_frame(8'hD0, 0, 1, 999, 1'b1, k);
        drain();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_moore_pattern_serializer
`default_nettype wire
